// File: rtl/game_sequencer_pkg.sv
// Shared pong definitions: phase encodings, edge columns, coordinate and timer widths.
package pong_pkg;

  localparam int unsigned COORD_W = 4;
  localparam int unsigned TIMER_W = 16;

  localparam logic [COORD_W-1:0] COL_LEFT  = 4'd0;
  localparam logic [COORD_W-1:0] COL_RIGHT = 4'd15;

  typedef enum logic [2:0] {
    PH_IDLE     = 3'd0,
    PH_SERVE    = 3'd1,
    PH_PLAY     = 3'd2,
    PH_POINT    = 3'd3,
    PH_GAMEOVER = 3'd4,
    PH_DEMO     = 3'd5
  } phase_e;

endpackage

// File: rtl/game_sequencer_if.sv
// Game-tick, button, coordinate inputs and ball/screen control outputs of the pong sequencer.
interface game_sequencer_if;
  import pong_pkg::*;

  logic                     tick;
  logic                     serve_btn;
  logic [COORD_W-1:0]       ball_x;
  logic [COORD_W-1:0]       ball_y;
  logic [COORD_W-1:0]       paddle_l;
  logic [COORD_W-1:0]       paddle_r;
  logic                     ball_rst;
  logic                     ball_en;
  logic signed [4:0]        speed;
  logic [3:0]               score_l;
  logic [3:0]               score_r;
  logic                     flash;
  logic [2:0]               phase;

  modport master (
    output tick, serve_btn, ball_x, ball_y, paddle_l, paddle_r,
    input  ball_rst, ball_en, speed, score_l, score_r, flash, phase
  );

  modport slave (
    input  tick, serve_btn, ball_x, ball_y, paddle_l, paddle_r,
    output ball_rst, ball_en, speed, score_l, score_r, flash, phase
  );

endinterface

// File: rtl/game_sequencer_tick_timer.sv
// Loadable down-counter of game ticks; o_done pulses on the tick that takes the count from 1 to 0.
module tick_timer #(
  parameter int unsigned     W         = 16,
  parameter logic [W-1:0]    RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_tick,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= RESET_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Independent of i_load so the owner may reload from o_done without a loop.
  assign o_done = i_tick && (r_cnt == W'(1));

endmodule

// File: rtl/game_sequencer.sv
// Pong game-level sequencer: serve/play/point/game-over phases, paddle judging, score and speed.
// Optional attract/demo mode is built when PONG_ATTRACT_EN is defined.
module game_sequencer
  import pong_pkg::*;
#(
  parameter int unsigned SERVE_TICKS      = 500,
  parameter int unsigned POINT_TICKS      = 1000,
  parameter int unsigned FLASH_TICKS      = 125,
  parameter int unsigned WIN_SCORE        = 9,
  parameter int unsigned PADDLE_H         = 3,
  parameter int unsigned SPEED_INIT       = 8,
  parameter int unsigned SPEED_MAX        = 15,
  parameter int unsigned HITS_PER_SPEEDUP = 4
`ifdef PONG_ATTRACT_EN
  , parameter int unsigned ATTRACT_TICKS  = 5000
`endif
) (
  input logic              clk,
  input logic              reset,
  game_sequencer_if.slave  gs
);

`ifdef PONG_ATTRACT_EN
  localparam logic [TIMER_W-1:0] IDLE_LOAD = TIMER_W'(ATTRACT_TICKS);
`else
  localparam logic [TIMER_W-1:0] IDLE_LOAD = '0;
`endif

  phase_e               r_state, w_nxt;
  logic                 r_btn_prev, r_btn_edge;
  logic [COORD_W-1:0]   r_prev_x;
  logic [3:0]           r_score_l, r_score_r, w_score_l, w_score_r;
  logic [4:0]           r_speed, w_speed;
  logic [7:0]           r_hits, w_hits;
  logic                 r_flash, w_flash;
  logic                 r_ball_rst, r_ball_en;
  logic                 w_phase_load, w_phase_done;
  logic [TIMER_W-1:0]   w_phase_val;
  logic                 w_flash_load, w_flash_done;
  logic                 w_edge_evt, w_hit, w_left;
  logic [COORD_W-1:0]   w_pad;
  logic [4:0]           w_pad_bot;
  logic                 w_win;

  tick_timer #(.W(TIMER_W), .RESET_VAL(IDLE_LOAD)) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .i_tick     (gs.tick),
    .i_load     (w_phase_load),
    .i_load_val (w_phase_val),
    .o_done     (w_phase_done)
  );

  tick_timer #(.W(TIMER_W), .RESET_VAL('0)) u_flash_timer (
    .clk        (clk),
    .reset      (reset),
    .i_tick     (gs.tick),
    .i_load     (w_flash_load),
    .i_load_val (TIMER_W'(FLASH_TICKS)),
    .o_done     (w_flash_done)
  );

  // Edge event fires only on the tick the ball first reaches an edge column.
  assign w_left     = (gs.ball_x == COL_LEFT);
  assign w_edge_evt = gs.tick && (w_left || (gs.ball_x == COL_RIGHT)) && (gs.ball_x != r_prev_x);
  assign w_pad      = w_left ? gs.paddle_l : gs.paddle_r;
  assign w_pad_bot  = {1'b0, w_pad} + 5'(PADDLE_H - 1);
  assign w_hit      = (gs.ball_y >= w_pad) && ({1'b0, gs.ball_y} <= w_pad_bot);
  assign w_win      = (r_score_l == 4'(WIN_SCORE)) || (r_score_r == 4'(WIN_SCORE));

  always_comb begin
    w_nxt     = r_state;
    w_score_l = r_score_l;
    w_score_r = r_score_r;
    w_speed   = r_speed;
    w_hits    = r_hits;
    w_flash   = 1'b0;
    case (r_state)
      PH_IDLE: begin
        if (r_btn_edge) w_nxt = PH_SERVE;
`ifdef PONG_ATTRACT_EN
        else if (w_phase_done) w_nxt = PH_DEMO;
`endif
      end
      PH_SERVE: begin
        if (w_phase_done) w_nxt = PH_PLAY;
      end
      PH_PLAY: begin
        if (w_edge_evt) begin
          if (w_hit) begin
            if ((r_hits + 8'd1) >= 8'(HITS_PER_SPEEDUP)) begin
              w_hits = '0;
              if (r_speed < 5'(SPEED_MAX)) w_speed = r_speed + 5'd1;
            end else begin
              w_hits = r_hits + 8'd1;
            end
          end else begin
            if (w_left) begin
              if (r_score_r != '1) w_score_r = r_score_r + 4'd1;
            end else begin
              if (r_score_l != '1) w_score_l = r_score_l + 4'd1;
            end
            w_nxt = PH_POINT;
          end
        end
      end
      PH_POINT: begin
        w_flash = r_flash;
        if (w_phase_done) begin
          w_flash = 1'b0;
          w_nxt   = w_win ? PH_GAMEOVER : PH_SERVE;
        end else if (w_flash_done) begin
          w_flash = ~r_flash;
        end
      end
      PH_GAMEOVER: begin
        if (r_btn_edge) begin
          w_score_l = '0;
          w_score_r = '0;
          w_nxt     = PH_SERVE;
        end
      end
      PH_DEMO: begin
        if (r_btn_edge) w_nxt = PH_SERVE;
      end
      default: w_nxt = PH_IDLE;
    endcase

    if (w_nxt == PH_SERVE) begin
      w_speed = 5'(SPEED_INIT);
      w_hits  = '0;
    end

    w_phase_load = (w_nxt != r_state);
    case (w_nxt)
      PH_SERVE: w_phase_val = TIMER_W'(SERVE_TICKS);
      PH_POINT: w_phase_val = TIMER_W'(POINT_TICKS);
      PH_IDLE:  w_phase_val = IDLE_LOAD;
      default:  w_phase_val = '0;
    endcase
    w_flash_load = ((w_nxt == PH_POINT) && (r_state != PH_POINT)) || w_flash_done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= PH_IDLE;
      r_btn_prev <= 1'b0;
      r_btn_edge <= 1'b0;
      r_prev_x   <= '0;
      r_score_l  <= '0;
      r_score_r  <= '0;
      r_speed    <= 5'(SPEED_INIT);
      r_hits     <= '0;
      r_flash    <= 1'b0;
      r_ball_rst <= 1'b1;
      r_ball_en  <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_btn_prev <= gs.serve_btn;
      r_btn_edge <= gs.serve_btn && !r_btn_prev;
      if (gs.tick) r_prev_x <= gs.ball_x;
      r_score_l  <= w_score_l;
      r_score_r  <= w_score_r;
      r_speed    <= w_speed;
      r_hits     <= w_hits;
      r_flash    <= w_flash;
      r_ball_rst <= (w_nxt inside {PH_IDLE, PH_SERVE, PH_POINT, PH_GAMEOVER});
      r_ball_en  <= (w_nxt inside {PH_PLAY, PH_DEMO});
    end
  end

  assign gs.ball_rst = r_ball_rst;
  assign gs.ball_en  = r_ball_en;
  assign gs.speed    = $signed(r_speed);
  assign gs.score_l  = r_score_l;
  assign gs.score_r  = r_score_r;
  assign gs.flash    = r_flash;
  assign gs.phase    = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed plus randomized bench for game_sequencer against an event-level game model.
module tb_game_sequencer;
  import pong_pkg::*;

  localparam int S_T = 4, P_T = 8, F_T = 2, WIN = 2, HPS = 2, PAD_H = 3, SP_I = 8, SP_M = 15, AT_T = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  game_sequencer_if bus();

  game_sequencer #(
    .SERVE_TICKS(S_T), .POINT_TICKS(P_T), .FLASH_TICKS(F_T), .WIN_SCORE(WIN),
    .HITS_PER_SPEEDUP(HPS)
`ifdef PONG_ATTRACT_EN
    , .ATTRACT_TICKS(AT_T)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .gs    (bus)
  );

  always #5 clk = ~clk;

  phase_e m_ph;
  int m_sl, m_sr, m_speed, m_hits, m_flash, m_timer, m_ftimer, m_prevx;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".phase"},   8'(bus.phase), 8'(m_ph));
    chk({tag, ".ball_rst"}, 8'(bus.ball_rst),
        8'(m_ph == PH_IDLE || m_ph == PH_SERVE || m_ph == PH_POINT || m_ph == PH_GAMEOVER));
    chk({tag, ".ball_en"}, 8'(bus.ball_en), 8'(m_ph == PH_PLAY || m_ph == PH_DEMO));
    chk({tag, ".speed"},   8'(bus.speed), 8'(m_speed));
    chk({tag, ".score_l"}, 8'(bus.score_l), 8'(m_sl));
    chk({tag, ".score_r"}, 8'(bus.score_r), 8'(m_sr));
    chk({tag, ".flash"},   8'(bus.flash), 8'(m_flash));
  endtask

  task automatic m_reset();
    m_ph = PH_IDLE; m_sl = 0; m_sr = 0; m_speed = SP_I; m_hits = 0; m_flash = 0;
    m_prevx = 0; m_ftimer = 0;
`ifdef PONG_ATTRACT_EN
    m_timer = AT_T;
`else
    m_timer = 0;
`endif
  endtask

  task automatic m_serve();
    m_ph = PH_SERVE; m_timer = S_T; m_speed = SP_I; m_hits = 0; m_flash = 0;
  endtask

  task automatic m_press();
    if (m_ph == PH_IDLE || m_ph == PH_DEMO) m_serve();
    else if (m_ph == PH_GAMEOVER) begin m_sl = 0; m_sr = 0; m_serve(); end
  endtask

  task automatic m_tick(input int x, input int y, input int pl, input int pr);
    int pad;
    case (m_ph)
      PH_IDLE: begin
`ifdef PONG_ATTRACT_EN
        if (m_timer > 0) begin m_timer--; if (m_timer == 0) m_ph = PH_DEMO; end
`endif
      end
      PH_SERVE: begin m_timer--; if (m_timer == 0) m_ph = PH_PLAY; end
      PH_PLAY: begin
        if ((x == 0 || x == 15) && x != m_prevx) begin
          pad = (x == 0) ? pl : pr;
          if (y >= pad && y <= pad + PAD_H - 1) begin
            m_hits++;
            if (m_hits == HPS) begin m_hits = 0; if (m_speed < SP_M) m_speed++; end
          end else begin
            if (x == 0) m_sr = (m_sr < 15) ? m_sr + 1 : 15;
            else        m_sl = (m_sl < 15) ? m_sl + 1 : 15;
            m_ph = PH_POINT; m_timer = P_T; m_ftimer = F_T; m_flash = 0;
          end
        end
      end
      PH_POINT: begin
        m_timer--; m_ftimer--;
        if (m_timer == 0) begin
          m_flash = 0;
          if (m_sl == WIN || m_sr == WIN) m_ph = PH_GAMEOVER; else m_serve();
        end else if (m_ftimer == 0) begin
          m_flash ^= 1; m_ftimer = F_T;
        end
      end
      default: ;
    endcase
    m_prevx = x;
  endtask

  task automatic do_tick(input int x, input int y);
    @(negedge clk);
    bus.ball_x = 4'(x); bus.ball_y = 4'(y); bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    m_tick(x, y, int'(bus.paddle_l), int'(bus.paddle_r));
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic press();
    @(negedge clk); bus.serve_btn = 1'b1;
    repeat (4) @(negedge clk);
    bus.serve_btn = 1'b0;
    @(negedge clk);
    m_press();
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_reset();
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin do_tick(7, 7); check_all(tag); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick = 1'b0; bus.serve_btn = 1'b0; bus.ball_x = 4'd7; bus.ball_y = 4'd7;
    bus.paddle_l = 4'd5; bus.paddle_r = 4'd0;
    do_reset();
    check_all("reset");

    // 1: serve sequence
    press();
    check_all("t1_serve");
    ticks(S_T, "t1_serve_tick");
    chk("t1_play_en", 8'(bus.ball_en), 8'd1);
    chk("t1_speed", 8'(bus.speed), 8'd8);

    // 2: hits, speed-up, dwell
    bus.paddle_l = 4'd5;
    do_tick(3, 7); check_all("t2_approach");
    do_tick(0, 7); check_all("t2_hit1");
    do_tick(0, 7); check_all("t2_dwell1");
    do_tick(0, 7); check_all("t2_dwell2");
    chk("t2_speed_after_one_hit", 8'(bus.speed), 8'd8);
    do_tick(4, 7); check_all("t2_away");
    do_tick(0, 5); check_all("t2_hit2");
    chk("t2_speed_up", 8'(bus.speed), 8'd9);

    // 3: right miss, POINT with flash, back to SERVE
    bus.paddle_r = 4'd0;
    do_tick(15, 3); check_all("t3_miss");
    chk("t3_score_l", 8'(bus.score_l), 8'd1);
    ticks(P_T, "t3_point");
    chk("t3_back_serve", 8'(bus.phase), 8'(PH_SERVE));

    // 4: second left point -> GAMEOVER, button clears
    ticks(S_T, "t4_serve");
    do_tick(15, 12); check_all("t4_miss");
    ticks(P_T, "t4_point");
    chk("t4_gameover", 8'(bus.phase), 8'(PH_GAMEOVER));
    press(); check_all("t4_restart");
    chk("t4_score_clr", 8'(bus.score_l), 8'd0);

    // randomized play
    for (int i = 0; i < 300; i++) begin
      int r, x;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        press(); check_all("rnd_press");
      end else begin
        bus.paddle_l = 4'($urandom_range(0, 15));
        bus.paddle_r = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 3))
          0: x = 0;
          1: x = 15;
          default: x = $urandom_range(0, 15);
        endcase
        do_tick(x, $urandom_range(0, 15)); check_all("rnd_tick");
      end
    end

    // 5: reset mid-PLAY at 1:1, speed 9
    do_reset(); press();
    ticks(S_T, "t5_serve");
    bus.paddle_l = 4'd0; bus.paddle_r = 4'd0;
    do_tick(0, 10); check_all("t5_miss_l");
    ticks(P_T + S_T, "t5_cycle");
    do_tick(15, 10); check_all("t5_miss_r");
    ticks(P_T + S_T, "t5_cycle2");
    bus.paddle_l = 4'd5;
    do_tick(0, 6); do_tick(5, 6); do_tick(0, 6); check_all("t5_pre_reset");
    chk("t5_speed9", 8'(bus.speed), 8'd9);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    m_reset();
    check_all("t5_reset");
    @(negedge clk); reset = 1'b0;

    // 6: attract / idle wait
    ticks(AT_T, "t6_idle");
`ifdef PONG_ATTRACT_EN
    chk("t6_demo", 8'(bus.phase), 8'(PH_DEMO));
`else
    chk("t6_still_idle", 8'(bus.phase), 8'(PH_IDLE));
`endif
    bus.paddle_l = 4'd0;
    do_tick(0, 10); check_all("t6_miss");
    press(); check_all("t6_press");
    chk("t6_serve", 8'(bus.phase), 8'(PH_SERVE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
